// File: rtl/diag_feeder.sv
// Diagonal skew feeder: buffers a 4x4 matrix row by row, then streams it out
// as 7 anti-diagonal beats across 4 lanes for the downstream aggregator.
module diag_feeder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] a3,
    input  logic [31:0] a4,
    input  logic        abort,
    output logic        out_valid,
    output logic [31:0] d1,
    output logic [31:0] d2,
    output logic [31:0] d3,
    output logic [31:0] d4,
    output logic [3:0]  lane_en,
    output logic [5:0]  count,
    output logic        out_last
);

    localparam int unsigned DW    = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned CW    = 6;
    localparam int unsigned BW    = 3;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [1:0]                           r_row_ptr;
    logic [1:0]                           w_row_ptr_nxt;
    logic [BW-1:0]                        r_beat;
    logic [BW-1:0]                        w_beat_nxt;
    logic                                 w_store;
    logic [LANES-1:0][LANES-1:0][DW-1:0]  r_mat;
    logic [LANES-1:0][DW-1:0]             w_d;
    logic [LANES-1:0]                     w_lane_en;

    // State, row pointer and beat index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LOAD;
            r_row_ptr <= '0;
            r_beat    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_ptr <= w_row_ptr_nxt;
            r_beat    <= w_beat_nxt;
        end
    end

    // Matrix storage; column 0 sits in the lowest word of each row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mat <= '0;
        end else if (w_store) begin
            r_mat[r_row_ptr] <= {a4, a3, a2, a1};
        end
    end

    // Next-state logic; abort wins over any accept on the same edge
    always_comb begin
        w_state_nxt   = r_state;
        w_row_ptr_nxt = r_row_ptr;
        w_beat_nxt    = r_beat;
        w_store       = 1'b0;
        if (abort) begin
            w_state_nxt   = LOAD;
            w_row_ptr_nxt = '0;
            w_beat_nxt    = '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        w_store = 1'b1;
                        if (r_row_ptr == 2'd3) begin
                            w_state_nxt   = EMIT;
                            w_row_ptr_nxt = '0;
                            w_beat_nxt    = '0;
                        end else begin
                            w_row_ptr_nxt = r_row_ptr + 2'd1;
                        end
                    end
                end
                EMIT: begin
                    if (r_beat == BW'(6)) begin
                        w_state_nxt = LOAD;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat + BW'(1);
                    end
                end
                default: w_state_nxt = LOAD;
            endcase
        end
    end

    // Anti-diagonal lane select: rising half (beats 0..3), falling half (4..6)
    always_comb begin
        w_lane_en = '0;
        w_d       = '0;
        if (r_state == EMIT) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (r_beat <= BW'(3)) begin
                    if (BW'(i) <= r_beat) begin
                        w_lane_en[i] = 1'b1;
                        w_d[i]       = r_mat[i][2'(r_beat - BW'(i))];
                    end
                end else if (BW'(i) <= BW'(6) - r_beat) begin
                    w_lane_en[i] = 1'b1;
                    w_d[i]       = r_mat[2'(r_beat - BW'(3) + BW'(i))][2'(3 - i)];
                end
            end
        end
    end

    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == EMIT);
    assign out_last  = (r_state == EMIT) && (r_beat == BW'(6));
    assign count     = (r_state == EMIT) ? CW'(r_beat) : '0;
    assign lane_en   = w_lane_en;
    assign d1        = w_d[0];
    assign d2        = w_d[1];
    assign d3        = w_d[2];
    assign d4        = w_d[3];

endmodule

// File: doc/diag_feeder.md
DIAG_FEEDER -- requirements
Module: diag_feeder

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-low (`rst_n`). No parameters; lane count is fixed at 4 and data width at 32.
REQ-002 Port `clk`, input, 1: rising-edge clock.
REQ-003 Port `rst_n`, input, 1: asynchronous active-low reset.
REQ-004 Port `in_valid`, input, 1: a matrix row is presented on `a1`..`a4`.
REQ-005 Port `in_ready`, output, 1: the block accepts a row this cycle.
REQ-006 Ports `a1`,`a2`,`a3`,`a4`, input, 32 each: row elements for columns 0..3.
REQ-007 Port `abort`, input, 1: synchronous flush of the current load or emit.
REQ-008 Port `out_valid`, output, 1: a diagonal beat is on `d1`..`d4`.
REQ-009 Ports `d1`,`d2`,`d3`,`d4`, output, 32 each: skewed lane data for the downstream aggregator.
REQ-010 Port `lane_en`, output, 4: per-lane valid, where bit0 is `d1`.
REQ-011 Port `count`, output, 6: beat index 0..6, matching the aggregator count input.
REQ-012 Port `out_last`, output, 1: marks beat 6.

Function
REQ-013 The block SHALL have two states: LOAD and EMIT.
REQ-014 In LOAD, `in_ready`=1 and a row SHALL be accepted on each edge with `in_valid`=1.
- Rows are stored into matrix row `row_ptr` (0..3); `row_ptr` then increments.
REQ-015 On the edge accepting row 3, the block SHALL go to EMIT with `row_ptr`=0 and `beat`=0.
REQ-016 In EMIT, `in_ready`=0; `in_valid` SHALL be ignored and no row is stored.
REQ-017 `out_valid` SHALL equal (state==EMIT).
- `d*`, `lane_en`, `count` and `out_last` derive from the stored matrix and `beat`.
- First beat appears in the cycle after the 4th accept edge (latency 1 cycle).
REQ-018 For beat k = 0..3, lane l (1..4) SHALL carry M[l-1][k-l+1] for l <= k+1; lane_en = (1<<(k+1))-1.
REQ-019 For beat k = 4..6, lane l SHALL carry M[k-4+l][4-l] for l <= 7-k; lane_en = (1<<(7-k))-1.
REQ-020 Lanes with lane_en bit 0, and all `d*` while `out_valid`=0, SHALL read 32'h0.
REQ-021 `count` SHALL equal `beat` in EMIT and 0 in LOAD.
REQ-022 `out_last` SHALL be 1 only when `beat`=6.
REQ-023 `beat` SHALL increment every EMIT cycle with no backpressure.
- On the edge at beat 6, the block returns to LOAD with `beat`=0.
- `in_ready`=1 in the following cycle; a back-to-back matrix therefore costs 4 load + 7 emit = 11 cycles.
REQ-024 `abort`=1 on an edge SHALL force LOAD, `row_ptr`=0 and `beat`=0.
- Stored matrix contents are retained but are stale.
- `abort` has priority over a simultaneous row accept, and no row is stored on that edge.
REQ-025 Partial loads (fewer than 4 rows) SHALL wait indefinitely in LOAD; gaps in `in_valid` are allowed.
REQ-026 Data SHALL pass unmodified; no arithmetic is performed on data.

Reset
REQ-027 While `rst_n`=0, the following SHALL hold immediately, independent of `clk`:
- state = LOAD; `row_ptr`, `beat` and all 16 matrix words = 0.
- `out_valid`, `out_last` and `lane_en` = 0; `count` = 0; `d1`..`d4` = 0; `in_ready` = 1.
REQ-028 Reset asserted mid-EMIT or mid-LOAD SHALL discard the operation; the first edge after release behaves as LOAD row 0.

Verification
REQ-029 Basic skew: load rows {0,1,2,3},{4,5,6,7},{8,9,a,b},{c,d,e,f} on 4 consecutive cycles -> 7 beats with:
- beat0 d1=0, lane_en=0001
- beat1 d1=1, d2=4, lane_en=0011
- beat2 d1=2, d2=5, d3=8, lane_en=0111
- beat3 d1=3, d2=6, d3=9, d4=c, lane_en=1111
- beat4 d1=7, d2=a, d3=d, lane_en=0111
- beat5 d1=b, d2=e, lane_en=0011
- beat6 d1=f, lane_en=0001, out_last=1
- `count`=0..6 and unused lanes=0.
REQ-030 Gapped load: same rows with `in_valid` low 2 cycles between rows -> identical beat sequence; first beat 1 cycle after the 4th accept.
REQ-031 Back-to-back: second matrix (each word +0x10) offered continuously.
- `in_ready`=0 for exactly 7 cycles.
- Second burst begins 5 cycles after the first `out_last`; beat3 = 13,16,19,1c.
REQ-032 Ignore during EMIT: `in_valid`=1 with junk rows throughout EMIT -> output unchanged; `row_ptr`=0 at the next LOAD.
REQ-033 Abort: `abort` at beat 3 -> `out_valid`=0 the next cycle.
- `abort` coincident with a row-2 accept -> 4 fresh rows are required before any emit.
REQ-034 Reset: `rst_n` pulsed low asynchronously at beat 2 -> all outputs 0 and `in_ready`=1 before the next edge; a full reload then reproduces REQ-029.
